fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Instruction-fetch address generator that sits directly upstream of the branch predictor and drives the L1 instruction-fetch request port. Each accepted fetch address is also sent as a predictor search, and the registered prediction that returns one cycle later steers the next fetch address. Execute-stage jump/mispredict redirects have absolute priority and flush the predictor.

## Interface
- P_RESET_VECTOR, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- iCLOCK  in  1  clock, rising-edge.
- inRESET  in  1  reset, asynchronous, active-low.
- iENABLE  in  1  level; fetch runs while high.
- iJUMP_VALID  in  1  redirect pulse from execute (taken branch, mispredict, exception).
- iJUMP_ADDR  in  32  redirect target; bits [1:0] ignored.
- oINST_REQ  out  1  fetch request valid.
- oINST_ADDR  out  32  fetch address, word-aligned.
- oINST_PREDICT_TAKEN  out  1  current request address came from a predicted-taken target.
- iINST_BUSY  in  1  fetch port cannot accept; request and address are held.
- oPREDICT_SEARCH_STB  out  1  predictor search strobe.
- oPREDICT_SEARCH_ADDR  out  32  predictor search address, equal to oINST_ADDR.
- oPREDICT_LOCK  out  1  freezes the predictor's output latch.
- oPREDICT_FLUSH  out  1  predictor flush pulse.
- iPREDICT_VALID  in  1  predictor output valid; registered, one cycle after search.
- iPREDICT_BRANCH  in  1  predicted taken.
- iPREDICT_ADDR  in  32  predicted target.

## Operation
- States:
  - IDLE: after reset, or when iENABLE is low.
  - FETCH: issuing requests.
  - REDIRECT: single-cycle bubble after a jump.
- Transitions:
  - IDLE -> FETCH when iENABLE=1.
  - FETCH -> IDLE when iENABLE=0 and no request is held (oINST_REQ=0 or iINST_BUSY=0).
  - Any state -> REDIRECT on iJUMP_VALID.
  - REDIRECT -> FETCH, or IDLE if iENABLE=0.
- Registers:
  - pc: address of the current request.
  - pend: a search was accepted in the previous cycle.
- Request behaviour:
  - FETCH: oINST_REQ=1 and oINST_ADDR=next_addr.
  - Accept is oINST_REQ && !iINST_BUSY.
  - On accept: oPREDICT_SEARCH_STB=1, pend<=1, pc<=oINST_ADDR.
  - No accept: pend<=0.
- next_addr:
  - pend && iPREDICT_VALID && iPREDICT_BRANCH: iPREDICT_ADDR & ~3; oINST_PREDICT_TAKEN=1.
  - pend otherwise: pc+4.
  - !pend (held or first request): pc held, i.e. the held address. oINST_PREDICT_TAKEN repeats its registered value.
- Held-address capture:
  - The address chosen in the first cycle after an accept is captured into a hold register even if iINST_BUSY=1.
  - Reissue while stalled uses the hold register; the prediction is never re-sampled.
- oPREDICT_LOCK = oINST_REQ && iINST_BUSY.
- Jump redirect (iJUMP_VALID=1, any state):
  - oINST_REQ=0 and oPREDICT_SEARCH_STB=0 in that cycle.
  - oPREDICT_FLUSH=1 that cycle.
  - pend<=0; the address register is loaded with iJUMP_ADDR & ~3.
  - In REDIRECT, the predictor result is ignored. The first FETCH request uses the jump address.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0.
- Simultaneous events:
  - iJUMP_VALID beats predicted-taken, busy, and iENABLE=0.
  - Jump while busy drops the held request.
- A jump arriving in IDLE is stored and fetched when iENABLE rises.

## Timing
- Reset values:
  - All outputs 0, except oINST_ADDR = oPREDICT_SEARCH_ADDR = P_RESET_VECTOR.
  - State IDLE, pend=0.
- First request: the cycle after iENABLE is sampled high.
- Predictor latency: 1 cycle. A taken prediction for a request accepted in cycle n steers the request of cycle n+1 with zero bubble.
- Jump to first redirected request: 2 cycles (the jump cycle plus REDIRECT).
- Throughput: one accept per cycle with no busy.
- Reset mid-stall: outputs return to reset values asynchronously; no request is reissued.

## Configuration
- MIST1032ISA_FETCH_BRANCH_PREDICT_EN:
  - Defined: prediction steering as above.
  - Undefined:
    - next_addr is always pc+4 (or the jump target).
    - oINST_PREDICT_TAKEN=0, oPREDICT_SEARCH_STB=0, oPREDICT_LOCK=0.
    - oPREDICT_FLUSH is still pulsed on jump.
    - iPREDICT_* inputs are ignored.

## Test plan
- Reset, iENABLE=1, no busy, predictor never taken -> addresses 0,4,8,C on consecutive cycles; STB each cycle.
- Request 0x100 accepted; next cycle iPREDICT_VALID=1, BRANCH=1, ADDR=0x2003 -> that cycle oINST_ADDR=0x2000 and oINST_PREDICT_TAKEN=1; following request 0x2004.
- Same as previous, but iINST_BUSY=1 for 3 cycles in the target cycle -> 0x2000 held with LOCK=1 and no STB; accepted on the 4th cycle; next request 0x2004.
- iJUMP_VALID with ADDR=0x4001 while a predicted-taken result is present -> FLUSH pulse, REQ=0 for 2 cycles, then 0x4000; the prediction is never used.
- pc=0xFFFF_FFFC accepted, no prediction -> next request 0x0.
- With the macro undefined, a taken prediction to 0x2000 -> requests stay sequential and STB stays 0.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// ----------------------------------------------------------------------------
// fetch_pc_gen
//
// Instruction-fetch address generator. It issues word-aligned fetch requests
// to the L1 instruction port and sends each accepted address to the branch
// predictor as a search. The registered prediction returned one cycle later
// steers the next fetch address. Execute-stage redirects take priority over
// everything else, flush the predictor and cost one bubble cycle.
//
// Optional feature macro: MIST1032ISA_FETCH_BRANCH_PREDICT_EN
//   defined   : predictor search/lock/taken outputs are live and a taken
//               prediction steers the next fetch address.
//   undefined : fetch is purely sequential (pc+4 or jump target). The search
//               strobe, lock and taken outputs stay 0, iPREDICT_* are ignored
//               and the flush pulse is still produced on a jump.
//
// Ports
//   iCLOCK, inRESET       : clock (rising edge), async active-low reset
//   iENABLE               : fetch runs while high
//   iJUMP_VALID/ADDR      : redirect from execute (ADDR[1:0] ignored)
//   oINST_REQ/ADDR        : fetch request and word-aligned address
//   oINST_PREDICT_TAKEN   : request address came from a predicted-taken target
//   iINST_BUSY            : fetch port stall; request and address are held
//   oPREDICT_SEARCH_STB   : predictor search strobe (one per accepted request)
//   oPREDICT_SEARCH_ADDR  : predictor search address (same as oINST_ADDR)
//   oPREDICT_LOCK         : freezes the predictor output latch during a stall
//   oPREDICT_FLUSH        : predictor flush pulse on a redirect
//   iPREDICT_VALID/BRANCH/ADDR : registered prediction, one cycle after search
// ----------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter logic [31:0] P_RESET_VECTOR = 32'h0000_0000
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iENABLE,
    input  logic        iJUMP_VALID,
    input  logic [31:0] iJUMP_ADDR,
    output logic        oINST_REQ,
    output logic [31:0] oINST_ADDR,
    output logic        oINST_PREDICT_TAKEN,
    input  logic        iINST_BUSY,
    output logic        oPREDICT_SEARCH_STB,
    output logic [31:0] oPREDICT_SEARCH_ADDR,
    output logic        oPREDICT_LOCK,
    output logic        oPREDICT_FLUSH,
    input  logic        iPREDICT_VALID,
    input  logic        iPREDICT_BRANCH,
    input  logic [31:0] iPREDICT_ADDR
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // r_pc always holds the address presented in the previous cycle, so it is
    // both the base for pc+4 after an accept and the held address during a
    // stall (the first post-accept choice is captured even when busy).
    logic [31:0] r_pc;
    logic        r_pend;
    logic        r_taken;

    logic        w_req;
    logic        w_accept;
    logic        w_taken;
    logic [31:0] w_next_addr;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = r_pc + 32'd4;

    always_comb begin
        w_next_addr = r_pc;
        w_taken     = r_taken;
        if (r_pend) begin
            w_next_addr = w_pc_inc;
            w_taken     = 1'b0;
`ifdef MIST1032ISA_FETCH_BRANCH_PREDICT_EN
            if (iPREDICT_VALID && iPREDICT_BRANCH) begin
                w_next_addr = {iPREDICT_ADDR[31:2], 2'b00};
                w_taken     = 1'b1;
            end
`endif
        end
    end

    // A jump in the same cycle suppresses the request outright.
    assign w_req    = (r_state == ST_FETCH) && !iJUMP_VALID;
    assign w_accept = w_req && !iINST_BUSY;

    assign oINST_REQ            = w_req;
    assign oINST_ADDR           = w_next_addr;
    assign oPREDICT_SEARCH_ADDR = w_next_addr;
    assign oPREDICT_FLUSH       = iJUMP_VALID;
    assign oINST_PREDICT_TAKEN  = w_req && w_taken;

`ifdef MIST1032ISA_FETCH_BRANCH_PREDICT_EN
    assign oPREDICT_SEARCH_STB = w_accept;
    assign oPREDICT_LOCK       = w_req && iINST_BUSY;

    logic w_unused_low_bits;
    assign w_unused_low_bits = ^{iJUMP_ADDR[1:0], iPREDICT_ADDR[1:0]};
`else
    assign oPREDICT_SEARCH_STB = 1'b0;
    assign oPREDICT_LOCK       = 1'b0;

    logic w_unused_predict;
    assign w_unused_predict = ^{iJUMP_ADDR[1:0], iPREDICT_VALID,
                                iPREDICT_BRANCH, iPREDICT_ADDR};
`endif

    always_comb begin
        w_state_next = r_state;
        if (iJUMP_VALID) begin
            w_state_next = ST_REDIRECT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iENABLE) w_state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    // A stalled request must complete before going idle.
                    if (!iENABLE && !iINST_BUSY) w_state_next = ST_IDLE;
                end
                ST_REDIRECT: begin
                    w_state_next = iENABLE ? ST_FETCH : ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_pc    <= P_RESET_VECTOR;
            r_pend  <= 1'b0;
            r_taken <= 1'b0;
        end else if (iJUMP_VALID) begin
            // Any prediction in flight is discarded; the target is fetched
            // after the redirect bubble (or when enable rises).
            r_pc    <= {iJUMP_ADDR[31:2], 2'b00};
            r_pend  <= 1'b0;
            r_taken <= 1'b0;
        end else begin
            r_pc    <= w_next_addr;
            r_pend  <= w_accept;
            r_taken <= w_taken;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
`timescale 1ns/1ps
module tb_fetch_pc_gen;

`ifdef MIST1032ISA_FETCH_BRANCH_PREDICT_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iENABLE = 1'b0;
    logic        iJUMP_VALID = 1'b0;
    logic [31:0] iJUMP_ADDR = 32'h0;
    logic        iINST_BUSY = 1'b0;
    logic        iPREDICT_VALID = 1'b0;
    logic        iPREDICT_BRANCH = 1'b0;
    logic [31:0] iPREDICT_ADDR = 32'h0;
    logic        oINST_REQ;
    logic [31:0] oINST_ADDR;
    logic        oINST_PREDICT_TAKEN;
    logic        oPREDICT_SEARCH_STB;
    logic [31:0] oPREDICT_SEARCH_ADDR;
    logic        oPREDICT_LOCK;
    logic        oPREDICT_FLUSH;

    fetch_pc_gen #(.P_RESET_VECTOR(32'h0000_0000)) dut (
        .iCLOCK               (iCLOCK),
        .inRESET              (inRESET),
        .iENABLE              (iENABLE),
        .iJUMP_VALID          (iJUMP_VALID),
        .iJUMP_ADDR           (iJUMP_ADDR),
        .oINST_REQ            (oINST_REQ),
        .oINST_ADDR           (oINST_ADDR),
        .oINST_PREDICT_TAKEN  (oINST_PREDICT_TAKEN),
        .iINST_BUSY           (iINST_BUSY),
        .oPREDICT_SEARCH_STB  (oPREDICT_SEARCH_STB),
        .oPREDICT_SEARCH_ADDR (oPREDICT_SEARCH_ADDR),
        .oPREDICT_LOCK        (oPREDICT_LOCK),
        .oPREDICT_FLUSH       (oPREDICT_FLUSH),
        .iPREDICT_VALID       (iPREDICT_VALID),
        .iPREDICT_BRANCH      (iPREDICT_BRANCH),
        .iPREDICT_ADDR        (iPREDICT_ADDR)
    );

    always #5 iCLOCK = ~iCLOCK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Apply inputs just after a rising edge, then move to the falling edge
    // where outputs are sampled.
    task automatic drive(input logic en, input logic jv, input logic [31:0] ja,
                         input logic busy, input logic pv, input logic pb,
                         input logic [31:0] pa);
        iENABLE = en; iJUMP_VALID = jv; iJUMP_ADDR = ja; iINST_BUSY = busy;
        iPREDICT_VALID = pv; iPREDICT_BRANCH = pb; iPREDICT_ADDR = pa;
        @(negedge iCLOCK);
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic reset_dut();
        inRESET = 1'b0;
        iENABLE = 0; iJUMP_VALID = 0; iJUMP_ADDR = 0; iINST_BUSY = 0;
        iPREDICT_VALID = 0; iPREDICT_BRANCH = 0; iPREDICT_ADDR = 0;
        repeat (2) @(posedge iCLOCK);
        @(negedge iCLOCK);
        chk("rst_req",   {31'b0, oINST_REQ}, 32'd0);
        chk("rst_addr",  oINST_ADDR, 32'h0);
        chk("rst_saddr", oPREDICT_SEARCH_ADDR, 32'h0);
        chk("rst_misc",  {28'b0, oINST_PREDICT_TAKEN, oPREDICT_SEARCH_STB,
                          oPREDICT_LOCK, oPREDICT_FLUSH}, 32'd0);
        inRESET = 1'b1;
        tick();
    endtask

    // Jump to target: jump cycle, redirect bubble; returns at the cycle in
    // which the first request to the target is presented.
    task automatic go(input logic [31:0] target);
        drive(1, 1, target, 0, 0, 0, 0);
        chk("go_flush", {31'b0, oPREDICT_FLUSH}, 32'd1);
        chk("go_req0",  {31'b0, oINST_REQ}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("go_req1",  {31'b0, oINST_REQ}, 32'd0);
        tick();
    endtask

    // ---------------- reference model ----------------
    // Fetch-level view: whether requests are being issued, whether the last
    // cycle's request was taken by the port, and the address/taken flag shown.
    logic        m_run, m_redir, m_acc, m_tk;
    logic [31:0] m_pc;
    logic        e_req, e_tk, e_stb, e_lock, e_flush, c_tk;
    logic [31:0] e_addr;

    task automatic model_reset();
        m_run = 0; m_redir = 0; m_acc = 0; m_tk = 0; m_pc = 32'h0;
    endtask

    task automatic model_eval();
        e_req = m_run && !iJUMP_VALID;
        if (m_acc && PE && iPREDICT_VALID && iPREDICT_BRANCH) begin
            e_addr = iPREDICT_ADDR & ~32'd3; c_tk = 1'b1;
        end else if (m_acc) begin
            e_addr = m_pc + 32'd4; c_tk = 1'b0;
        end else begin
            e_addr = m_pc; c_tk = m_tk;
        end
        e_tk    = e_req && c_tk;
        e_stb   = PE && e_req && !iINST_BUSY;
        e_lock  = PE && e_req && iINST_BUSY;
        e_flush = iJUMP_VALID;
    endtask

    task automatic model_step();
        if (iJUMP_VALID) begin
            m_pc = iJUMP_ADDR & ~32'd3; m_tk = 0; m_acc = 0;
            m_run = 0; m_redir = 1;
        end else begin
            m_pc = e_addr; m_tk = c_tk; m_acc = e_req && !iINST_BUSY;
            if (m_redir) begin m_redir = 0; m_run = iENABLE; end
            else if (!m_run) m_run = iENABLE;
            else m_run = iENABLE || iINST_BUSY;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en, busy, jv;
        logic [31:0] ja;
        logic        req;
        logic [31:0] addr;
        logic        chk_addr;
        logic        stb, lock, flush;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic en, input logic busy, input logic jv,
                                input logic [31:0] ja, input logic req,
                                input logic [31:0] addr, input logic ca,
                                input logic stb, input logic lock, input logic flush);
        vec_t v;
        v.en = en; v.busy = busy; v.jv = jv; v.ja = ja; v.req = req;
        v.addr = addr; v.chk_addr = ca; v.stb = stb; v.lock = lock; v.flush = flush;
        return v;
    endfunction

    logic [31:0] x1;

    initial begin
        tbl[0]  = mk(1, 0, 0, 0,          0, 32'h0,    1, 0,  0,  0);
        tbl[1]  = mk(1, 0, 0, 0,          1, 32'h0,    1, PE, 0,  0);
        tbl[2]  = mk(1, 0, 0, 0,          1, 32'h4,    1, PE, 0,  0);
        tbl[3]  = mk(1, 0, 0, 0,          1, 32'h8,    1, PE, 0,  0);
        tbl[4]  = mk(1, 0, 0, 0,          1, 32'hC,    1, PE, 0,  0);
        tbl[5]  = mk(1, 1, 0, 0,          1, 32'h10,   1, 0,  PE, 0);
        tbl[6]  = mk(1, 1, 0, 0,          1, 32'h10,   1, 0,  PE, 0);
        tbl[7]  = mk(1, 0, 0, 0,          1, 32'h10,   1, PE, 0,  0);
        tbl[8]  = mk(1, 0, 1, 32'h4001,   0, 32'h0,    0, 0,  0,  1);
        tbl[9]  = mk(1, 0, 0, 0,          0, 32'h0,    0, 0,  0,  0);
        tbl[10] = mk(1, 0, 0, 0,          1, 32'h4000, 1, PE, 0,  0);
        tbl[11] = mk(0, 0, 0, 0,          1, 32'h4004, 1, PE, 0,  0);
        tbl[12] = mk(0, 0, 0, 0,          0, 32'h0,    0, 0,  0,  0);
        tbl[13] = mk(0, 0, 0, 0,          0, 32'h0,    0, 0,  0,  0);
        tbl[14] = mk(1, 0, 0, 0,          0, 32'h0,    0, 0,  0,  0);
        tbl[15] = mk(1, 0, 0, 0,          1, 32'h4008, 1, PE, 0,  0);

        reset_dut();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].jv, tbl[i].ja, tbl[i].busy, 0, 0, 0);
            chk($sformatf("vec%0d_req", i),   {31'b0, oINST_REQ},           {31'b0, tbl[i].req});
            chk($sformatf("vec%0d_stb", i),   {31'b0, oPREDICT_SEARCH_STB}, {31'b0, tbl[i].stb});
            chk($sformatf("vec%0d_lock", i),  {31'b0, oPREDICT_LOCK},       {31'b0, tbl[i].lock});
            chk($sformatf("vec%0d_flush", i), {31'b0, oPREDICT_FLUSH},      {31'b0, tbl[i].flush});
            chk($sformatf("vec%0d_taken", i), {31'b0, oINST_PREDICT_TAKEN}, 32'd0);
            if (tbl[i].chk_addr) begin
                chk($sformatf("vec%0d_addr", i),  oINST_ADDR,           tbl[i].addr);
                chk($sformatf("vec%0d_saddr", i), oPREDICT_SEARCH_ADDR, tbl[i].addr);
            end
            tick();
        end

        // Predicted-taken target steers the very next request.
        reset_dut();
        go(32'h100);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("pt_addr0", oINST_ADDR, 32'h100);
        chk("pt_stb0",  {31'b0, oPREDICT_SEARCH_STB}, {31'b0, PE});
        tick();
        drive(1, 0, 0, 0, 1, 1, 32'h2003);
        chk("pt_addr1",  oINST_ADDR, PE ? 32'h2000 : 32'h104);
        chk("pt_taken1", {31'b0, oINST_PREDICT_TAKEN}, {31'b0, PE});
        chk("pt_stb1",   {31'b0, oPREDICT_SEARCH_STB}, {31'b0, PE});
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("pt_addr2",  oINST_ADDR, PE ? 32'h2004 : 32'h108);
        chk("pt_taken2", {31'b0, oINST_PREDICT_TAKEN}, 32'd0);
        tick();

        // Predicted target stalled three cycles; prediction not resampled.
        x1 = PE ? 32'h2000 : 32'h104;
        go(32'h100);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 1, 32'h2003);
        chk("st_addr0", oINST_ADDR, x1);
        chk("st_lock0", {31'b0, oPREDICT_LOCK}, {31'b0, PE});
        chk("st_stb0",  {31'b0, oPREDICT_SEARCH_STB}, 32'd0);
        tick();
        for (int k = 1; k < 3; k++) begin
            drive(1, 0, 0, 1, 1, 1, 32'h3000);
            chk($sformatf("st_addr%0d", k),  oINST_ADDR, x1);
            chk($sformatf("st_taken%0d", k), {31'b0, oINST_PREDICT_TAKEN}, {31'b0, PE});
            chk($sformatf("st_lock%0d", k),  {31'b0, oPREDICT_LOCK}, {31'b0, PE});
            tick();
        end
        drive(1, 0, 0, 0, 1, 1, 32'h3000);
        chk("st_addr3", oINST_ADDR, x1);
        chk("st_stb3",  {31'b0, oPREDICT_SEARCH_STB}, {31'b0, PE});
        chk("st_lock3", {31'b0, oPREDICT_LOCK}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("st_addr4", oINST_ADDR, x1 + 32'd4);
        tick();

        // Jump beats a present taken prediction.
        go(32'h100);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 32'h4001, 0, 1, 1, 32'h2003);
        chk("jp_req0",   {31'b0, oINST_REQ}, 32'd0);
        chk("jp_flush0", {31'b0, oPREDICT_FLUSH}, 32'd1);
        chk("jp_stb0",   {31'b0, oPREDICT_SEARCH_STB}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 32'h2003);
        chk("jp_req1",   {31'b0, oINST_REQ}, 32'd0);
        chk("jp_flush1", {31'b0, oPREDICT_FLUSH}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("jp_req2",   {31'b0, oINST_REQ}, 32'd1);
        chk("jp_addr2",  oINST_ADDR, 32'h4000);
        chk("jp_taken2", {31'b0, oINST_PREDICT_TAKEN}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("jp_addr3", oINST_ADDR, 32'h4004);
        tick();

        // Address wrap at the top of the space.
        go(32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("wr_addr0", oINST_ADDR, 32'hFFFF_FFFC);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("wr_addr1", oINST_ADDR, 32'h0);
        chk("wr_req1",  {31'b0, oINST_REQ}, 32'd1);
        tick();

        // Asynchronous reset in the middle of a stall.
        go(32'h200);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("rs_req0", {31'b0, oINST_REQ}, 32'd1);
        #2 inRESET = 1'b0;
        #1;
        chk("rs_req1",  {31'b0, oINST_REQ}, 32'd0);
        chk("rs_addr1", oINST_ADDR, 32'h0);
        chk("rs_misc1", {29'b0, oPREDICT_SEARCH_STB, oPREDICT_LOCK, oINST_PREDICT_TAKEN}, 32'd0);
        tick();
        iENABLE = 0;
        @(negedge iCLOCK);
        inRESET = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            chk($sformatf("rs_noreq%0d", k), {31'b0, oINST_REQ}, 32'd0);
            tick();
        end

        // Randomized run against the reference model.
        reset_dut();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
                  (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7)) : $urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), $urandom);
            model_eval();
            chk("rnd_req",   {31'b0, oINST_REQ},           {31'b0, e_req});
            chk("rnd_addr",  oINST_ADDR,                   e_addr);
            chk("rnd_saddr", oPREDICT_SEARCH_ADDR,         e_addr);
            chk("rnd_taken", {31'b0, oINST_PREDICT_TAKEN}, {31'b0, e_tk});
            chk("rnd_stb",   {31'b0, oPREDICT_SEARCH_STB}, {31'b0, e_stb});
            chk("rnd_lock",  {31'b0, oPREDICT_LOCK},       {31'b0, e_lock});
            chk("rnd_flush", {31'b0, oPREDICT_FLUSH},      {31'b0, e_flush});
            model_step();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
